// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache, one word per line, sitting between the
// instruction fetcher and the memory management unit.
module inst_cache_dm #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  flush,
   input  logic                  valid_from_inst_fetcher,
   input  logic [ADDR_WIDTH-1:0] addr_from_inst_fetcher,
   output logic                  ready_to_inst_fetcher,
   output logic [DATA_WIDTH-1:0] data_to_inst_fetcher,
   output logic                  valid_to_mem_mgmt_unit,
   output logic [ADDR_WIDTH-1:0] addr_to_mem_mgmt_unit,
   input  logic                  ready_from_mem_mgmt_unit,
   input  logic [DATA_WIDTH-1:0] data_from_mem_mgmt_unit
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_MISS    = 2'd1;
   localparam logic [1:0] S_RESPOND = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]            state;
   logic [LINES-1:0]      line_valid;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [DATA_WIDTH-1:0] data_mem [LINES];

   logic [INDEX_BITS-1:0] lookup_index;
   logic [TAG_BITS-1:0]   lookup_tag;
   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_BITS-1:0]   fill_tag;
   logic                  lookup_hit;
   logic                  fill_write;
   logic                  unused_offset;

   assign lookup_index  = addr_from_inst_fetcher[INDEX_BITS+1:2];
   assign lookup_tag    = addr_from_inst_fetcher[ADDR_WIDTH-1:INDEX_BITS+2];
   assign unused_offset = ^addr_from_inst_fetcher[1:0];

   // The outstanding fill address doubles as the latched request address.
   assign fill_index = addr_to_mem_mgmt_unit[INDEX_BITS+1:2];
   assign fill_tag   = addr_to_mem_mgmt_unit[ADDR_WIDTH-1:INDEX_BITS+2];

   assign lookup_hit = line_valid[lookup_index] && (tag_mem[lookup_index] == lookup_tag);
   assign fill_write = rst && rdy && !flush && (state == S_MISS) && ready_from_mem_mgmt_unit;

   // Tag/data arrays carry no reset; only the valid bits gate their contents.
   always_ff @(posedge clk) begin
      if (fill_write) begin
         tag_mem[fill_index]  <= fill_tag;
         data_mem[fill_index] <= data_from_mem_mgmt_unit;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                  <= S_IDLE;
         line_valid             <= '0;
         ready_to_inst_fetcher  <= 1'b0;
         data_to_inst_fetcher   <= '0;
         valid_to_mem_mgmt_unit <= 1'b0;
         addr_to_mem_mgmt_unit  <= '0;
      end else if (rdy) begin
         ready_to_inst_fetcher <= 1'b0;
         if (flush) begin
            line_valid <= '0;
            case (state)
               S_MISS, S_DRAIN: begin
                  // The memory request cannot be withdrawn; wait it out in DRAIN.
                  if (ready_from_mem_mgmt_unit) begin
                     valid_to_mem_mgmt_unit <= 1'b0;
                     state                  <= S_IDLE;
                  end else begin
                     state <= S_DRAIN;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end else begin
            case (state)
               S_IDLE: begin
                  if (valid_from_inst_fetcher) begin
                     if (lookup_hit) begin
                        data_to_inst_fetcher  <= data_mem[lookup_index];
                        ready_to_inst_fetcher <= 1'b1;
                        state                 <= S_RESPOND;
                     end else begin
                        valid_to_mem_mgmt_unit <= 1'b1;
                        addr_to_mem_mgmt_unit  <= {addr_from_inst_fetcher[ADDR_WIDTH-1:2], 2'b00};
                        state                  <= S_MISS;
                     end
                  end
               end
               S_MISS: begin
                  if (ready_from_mem_mgmt_unit) begin
                     line_valid[fill_index] <= 1'b1;
                     data_to_inst_fetcher   <= data_from_mem_mgmt_unit;
                     valid_to_mem_mgmt_unit <= 1'b0;
                     ready_to_inst_fetcher  <= 1'b1;
                     state                  <= S_RESPOND;
                  end
               end
               S_RESPOND: state <= S_IDLE;
               default: begin
                  if (ready_from_mem_mgmt_unit) begin
                     valid_to_mem_mgmt_unit <= 1'b0;
                     state                  <= S_IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_cache_dm.sv
// Directed bench for inst_cache_dm: vector table of fetches plus hand-written
// flush, rdy-stall and reset sequences.
module tb_inst_cache_dm;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        flush;
   logic        valid_from_inst_fetcher;
   logic [31:0] addr_from_inst_fetcher;
   logic        ready_to_inst_fetcher;
   logic [31:0] data_to_inst_fetcher;
   logic        valid_to_mem_mgmt_unit;
   logic [31:0] addr_to_mem_mgmt_unit;
   logic        ready_from_mem_mgmt_unit;
   logic [31:0] data_from_mem_mgmt_unit;

   int checks = 0;
   int errors = 0;

   inst_cache_dm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_BITS(6)) dut (
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .flush(flush),
      .valid_from_inst_fetcher(valid_from_inst_fetcher),
      .addr_from_inst_fetcher(addr_from_inst_fetcher),
      .ready_to_inst_fetcher(ready_to_inst_fetcher),
      .data_to_inst_fetcher(data_to_inst_fetcher),
      .valid_to_mem_mgmt_unit(valid_to_mem_mgmt_unit),
      .addr_to_mem_mgmt_unit(addr_to_mem_mgmt_unit),
      .ready_from_mem_mgmt_unit(ready_from_mem_mgmt_unit),
      .data_from_mem_mgmt_unit(data_from_mem_mgmt_unit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] addr;
      int unsigned dly;
      logic [31:0] mem_data;
      bit          exp_miss;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issues one fetch, plays the memory side, checks miss/data/latency.
   task automatic fetch(input string name, input logic [31:0] a, input int unsigned dly,
                        input logic [31:0] md, input bit exp_miss, input logic [31:0] exp_data);
      bit          done    = 1'b0;
      bit          saw_mem = 1'b0;
      bit          fired   = 1'b0;
      int unsigned cnt     = 0;
      int unsigned lat     = 0;
      logic [31:0] got     = '0;
      logic [31:0] maddr   = '0;
      valid_from_inst_fetcher = 1'b1;
      addr_from_inst_fetcher  = a;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         ready_from_mem_mgmt_unit = 1'b0;
         if (ready_to_inst_fetcher) begin
            done = 1'b1;
            lat  = c;
            got  = data_to_inst_fetcher;
            break;
         end
         if (valid_to_mem_mgmt_unit && !saw_mem) begin
            saw_mem = 1'b1;
            maddr   = addr_to_mem_mgmt_unit;
            cnt     = dly;
         end
         if (saw_mem && !fired) begin
            if (cnt == 0) begin
               fired = 1'b1;
               ready_from_mem_mgmt_unit = 1'b1;
               data_from_mem_mgmt_unit  = md;
            end else begin
               cnt--;
            end
         end
      end
      valid_from_inst_fetcher = 1'b0;
      chk({name, " answered"}, 64'(done), 64'd1);
      if (done) begin
         chk({name, " miss"}, 64'(saw_mem), 64'(exp_miss));
         chk({name, " data"}, 64'(got), 64'(exp_data));
         chk({name, " latency"}, 64'(lat), exp_miss ? 64'(dly + 2) : 64'd1);
         if (exp_miss) chk({name, " fill addr"}, 64'(maddr), 64'(a & 32'hFFFF_FFFC));
      end
      @(negedge clk);
   endtask

   initial begin
      bit seen_ready;

      vecs[0]  = '{32'h0000_0100, 3, 32'h0010_0093, 1'b1, 32'h0010_0093};
      vecs[1]  = '{32'h0000_0100, 0, 32'h0000_0000, 1'b0, 32'h0010_0093};
      vecs[2]  = '{32'h0000_0102, 0, 32'h0000_0000, 1'b0, 32'h0010_0093};
      vecs[3]  = '{32'h0000_0200, 1, 32'h1111_2222, 1'b1, 32'h1111_2222};
      vecs[4]  = '{32'h0000_0100, 0, 32'h0010_0093, 1'b1, 32'h0010_0093};
      vecs[5]  = '{32'h0000_0204, 2, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001};
      vecs[6]  = '{32'h0000_0204, 0, 32'h0000_0000, 1'b0, 32'hA5A5_0001};
      vecs[7]  = '{32'h0000_0100, 0, 32'h0000_0000, 1'b0, 32'h0010_0093};
      vecs[8]  = '{32'hFFFF_FFFC, 1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
      vecs[9]  = '{32'hFFFF_FFFD, 0, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
      vecs[10] = '{32'h0000_00FC, 2, 32'h1234_5678, 1'b1, 32'h1234_5678};
      vecs[11] = '{32'hFFFF_FFFC, 0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D};

      rst = 1'b0;
      rdy = 1'b1;
      flush = 1'b0;
      valid_from_inst_fetcher  = 1'b0;
      addr_from_inst_fetcher   = '0;
      ready_from_mem_mgmt_unit = 1'b0;
      data_from_mem_mgmt_unit  = '0;
      repeat (3) @(negedge clk);
      chk("reset ready", 64'(ready_to_inst_fetcher), 64'd0);
      chk("reset mem valid", 64'(valid_to_mem_mgmt_unit), 64'd0);
      chk("reset data", 64'(data_to_inst_fetcher), 64'd0);
      chk("reset mem addr", 64'(addr_to_mem_mgmt_unit), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++)
         fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dly, vecs[i].mem_data,
               vecs[i].exp_miss, vecs[i].exp_data);

      // Stray memory ready in IDLE is ignored.
      ready_from_mem_mgmt_unit = 1'b1;
      data_from_mem_mgmt_unit  = 32'h7777_7777;
      @(negedge clk);
      ready_from_mem_mgmt_unit = 1'b0;
      chk("stray ready resp", 64'(ready_to_inst_fetcher), 64'd0);
      @(negedge clk);
      chk("stray ready mem valid", 64'(valid_to_mem_mgmt_unit), 64'd0);

      // Flush one cycle into a miss; the in-flight fill is drained and dropped.
      seen_ready = 1'b0;
      valid_from_inst_fetcher = 1'b1;
      addr_from_inst_fetcher  = 32'h0000_0400;
      @(negedge clk);
      chk("fmiss mem valid", 64'(valid_to_mem_mgmt_unit), 64'd1);
      @(negedge clk);
      flush = 1'b1;
      valid_from_inst_fetcher = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("fmiss drain valid", 64'(valid_to_mem_mgmt_unit), 64'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         seen_ready |= ready_to_inst_fetcher;
      end
      chk("fmiss drain hold", 64'(valid_to_mem_mgmt_unit), 64'd1);
      ready_from_mem_mgmt_unit = 1'b1;
      data_from_mem_mgmt_unit  = 32'hDEAD_BEEF;
      @(negedge clk);
      ready_from_mem_mgmt_unit = 1'b0;
      seen_ready |= ready_to_inst_fetcher;
      chk("fmiss valid dropped", 64'(valid_to_mem_mgmt_unit), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen_ready |= ready_to_inst_fetcher;
      end
      chk("fmiss no response", 64'(seen_ready), 64'd0);
      fetch("fmiss refetch", 32'h0000_0400, 1, 32'h0400_0400, 1'b1, 32'h0400_0400);
      fetch("fmiss old 100", 32'h0000_0100, 0, 32'h0010_0093, 1'b1, 32'h0010_0093);
      fetch("fmiss old 204", 32'h0000_0204, 1, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001);

      // Flush coincident with memory ready: data discarded, straight to IDLE.
      valid_from_inst_fetcher = 1'b1;
      addr_from_inst_fetcher  = 32'h0000_0300;
      @(negedge clk);
      chk("fco mem valid", 64'(valid_to_mem_mgmt_unit), 64'd1);
      ready_from_mem_mgmt_unit = 1'b1;
      data_from_mem_mgmt_unit  = 32'h3333_3333;
      flush = 1'b1;
      valid_from_inst_fetcher = 1'b0;
      @(negedge clk);
      ready_from_mem_mgmt_unit = 1'b0;
      flush = 1'b0;
      chk("fco mem valid dropped", 64'(valid_to_mem_mgmt_unit), 64'd0);
      chk("fco no resp", 64'(ready_to_inst_fetcher), 64'd0);
      @(negedge clk);
      chk("fco no resp later", 64'(ready_to_inst_fetcher), 64'd0);
      fetch("fco refetch", 32'h0000_0300, 2, 32'h0300_0300, 1'b1, 32'h0300_0300);

      // Flush in the RESPOND cycle, then flush in the lookup cycle.
      fetch("fresp fill", 32'h0000_0500, 0, 32'h0500_0500, 1'b1, 32'h0500_0500);
      valid_from_inst_fetcher = 1'b1;
      addr_from_inst_fetcher  = 32'h0000_0500;
      @(negedge clk);
      chk("fresp hit pulse", 64'(ready_to_inst_fetcher), 64'd1);
      flush = 1'b1;
      valid_from_inst_fetcher = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("fresp pulse cleared", 64'(ready_to_inst_fetcher), 64'd0);
      fetch("fresp refill", 32'h0000_0500, 1, 32'h0500_0501, 1'b1, 32'h0500_0501);
      valid_from_inst_fetcher = 1'b1;
      addr_from_inst_fetcher  = 32'h0000_0500;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      valid_from_inst_fetcher = 1'b0;
      chk("flookup no resp", 64'(ready_to_inst_fetcher), 64'd0);
      chk("flookup no mem", 64'(valid_to_mem_mgmt_unit), 64'd0);
      @(negedge clk);
      fetch("flookup refetch", 32'h0000_0500, 0, 32'h0500_0502, 1'b1, 32'h0500_0502);

      // rdy low mid-miss holds everything, including a memory ready pulse.
      valid_from_inst_fetcher = 1'b1;
      addr_from_inst_fetcher  = 32'h0000_0600;
      @(negedge clk);
      chk("stall mem valid", 64'(valid_to_mem_mgmt_unit), 64'd1);
      rdy = 1'b0;
      ready_from_mem_mgmt_unit = 1'b1;
      data_from_mem_mgmt_unit  = 32'h6666_6666;
      @(negedge clk);
      ready_from_mem_mgmt_unit = 1'b0;
      repeat (3) @(negedge clk);
      chk("stall mem valid held", 64'(valid_to_mem_mgmt_unit), 64'd1);
      chk("stall mem addr held", 64'(addr_to_mem_mgmt_unit), 64'h600);
      chk("stall no resp", 64'(ready_to_inst_fetcher), 64'd0);
      rdy = 1'b1;
      @(negedge clk);
      chk("stall pulse not consumed", 64'(valid_to_mem_mgmt_unit), 64'd1);
      chk("stall still no resp", 64'(ready_to_inst_fetcher), 64'd0);
      rst = 1'b0;
      valid_from_inst_fetcher = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midrst ready", 64'(ready_to_inst_fetcher), 64'd0);
      chk("midrst mem valid", 64'(valid_to_mem_mgmt_unit), 64'd0);
      chk("midrst data", 64'(data_to_inst_fetcher), 64'd0);
      chk("midrst mem addr", 64'(addr_to_mem_mgmt_unit), 64'd0);
      @(negedge clk);
      fetch("midrst 100", 32'h0000_0100, 1, 32'h0010_0093, 1'b1, 32'h0010_0093);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
